// File: rtl/simd_alu_pkg.sv
// Shared types for the bit-serial SIMD ALU: op codes, FSM states and op legality.
package simd_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_MULH = 3'd3,
    OP_DIVU = 3'd4,
    OP_REMU = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= 3'd5);
  endfunction

endpackage

// File: rtl/simd_serial_lane.sv
// One lane of the bit-serial ALU: latches operands on load, performs one micro-step per
// step pulse, and registers the lane result/flag on the final step.
module simd_serial_lane
  import simd_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic [$clog2(WIDTH)-1:0] k_i,
  input  logic [2:0]               op_i,
  input  logic                     en_i,
  input  logic [WIDTH-1:0]         a_i,
  input  logic [WIDTH-1:0]         b_i,
  output logic [WIDTH-1:0]         result_o,
  output logic                     flag_o
);

  localparam int KW = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic               en_q;
  logic               dbz_q;
  logic               carry_q, carry_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               flag_q, flag_d;

  logic               bit_b;
  logic [WIDTH:0]     rem_sh;
  logic [KW-1:0]      msb_idx;
  logic               last;

  assign msb_idx = KW'(WIDTH - 1) - k_i;
  assign last    = (k_i == KW'(WIDTH - 1));

  // quo doubles as the sum register for ADD/SUB, so bit k of the sum lands in quo[k].
  always_comb begin
    carry_d = carry_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bit_b   = 1'b0;
    rem_sh  = '0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        bit_b       = (op_q == OP_SUB) ? ~b_q[k_i] : b_q[k_i];
        quo_d[k_i]  = a_q[k_i] ^ bit_b ^ carry_q;
        carry_d     = (a_q[k_i] & bit_b) | (carry_q & (a_q[k_i] ^ bit_b));
      end
      OP_MUL, OP_MULH: begin
        if (b_q[k_i]) acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << k_i);
      end
      OP_DIVU, OP_REMU: begin
        rem_sh = {rem_q, a_q[msb_idx]};
        if (rem_sh >= {1'b0, b_q}) begin
          rem_d          = rem_sh[WIDTH-1:0] - b_q;
          quo_d[msb_idx] = 1'b1;
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    res_d  = '0;
    flag_d = 1'b0;
    case (op_q)
      OP_ADD:  begin res_d = quo_d;                    flag_d = carry_d;               end
      OP_SUB:  begin res_d = quo_d;                    flag_d = ~carry_d;              end
      OP_MUL:  begin res_d = acc_d[WIDTH-1:0];         flag_d = |acc_d[2*WIDTH-1:WIDTH]; end
      OP_MULH: begin res_d = acc_d[2*WIDTH-1:WIDTH];   flag_d = 1'b0;                  end
      OP_DIVU: begin res_d = dbz_q ? '1 : quo_d;       flag_d = dbz_q;                 end
      OP_REMU: begin res_d = dbz_q ? a_q : rem_d;      flag_d = dbz_q;                 end
      default: ;
    endcase
  end

  // Datapath state: loaded only for enabled lanes and stepped only while enabled.
  always_ff @(posedge clk) begin
    if (load_i && en_i) begin
      a_q     <= a_i;
      b_q     <= b_i;
      op_q    <= op_i;
      dbz_q   <= (b_i == '0);
      carry_q <= (op_i == OP_SUB);
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
    end else if (step_i && en_q) begin
      carry_q <= carry_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      res_q  <= '0;
      flag_q <= 1'b0;
    end else if (load_i) begin
      en_q   <= en_i;
      res_q  <= '0;
      flag_q <= 1'b0;
    end else if (step_i && en_q && last) begin
      res_q  <= res_d;
      flag_q <= flag_d;
    end
  end

  assign result_o = res_q;
  assign flag_o   = flag_q;

endmodule

// File: rtl/simd_serial_alu.sv
// Multi-lane bit-serial integer ALU: accepts one vector op, runs WIDTH micro-steps in
// every enabled lane, then holds the result until the consumer takes it or abort fires.
module simd_serial_alu
  import simd_alu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [LANES-1:0]       in_lane_en,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   abort,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_result,
  output logic [LANES-1:0]       out_flag,
  output logic                   out_err
);

  localparam int KW = $clog2(WIDTH);

  state_e                 state_q, state_d;
  logic [KW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   accept, step, last_step;
  logic [LANES*WIDTH-1:0] lane_res;
  logic [LANES-1:0]       lane_flag;

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_q == KW'(WIDTH - 1));
  assign step      = (state_q == BUSY) && !abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = '0;
          err_d   = !is_legal_op(in_op);
        end
      end
      BUSY: begin
        if (abort)          state_d = IDLE;
        else if (last_step) state_d = DONE;
        else                cnt_d   = cnt_q + KW'(1);
      end
      DONE: begin
        if (abort || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_serial_lane #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (accept),
      .step_i   (step),
      .k_i      (cnt_q),
      .op_i     (in_op),
      .en_i     (in_lane_en[i]),
      .a_i      (in_a[i*WIDTH +: WIDTH]),
      .b_i      (in_b[i*WIDTH +: WIDTH]),
      .result_o (lane_res[i*WIDTH +: WIDTH]),
      .flag_o   (lane_flag[i])
    );
  end

  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = out_valid ? lane_res : '0;
  assign out_flag   = out_valid ? lane_flag : '0;
  assign out_err    = out_valid && err_q;

endmodule

// File: tb/tb_simd_serial_alu.sv
// Randomised self-checking bench for simd_serial_alu (LANES=4, WIDTH=8) against an
// arithmetic reference model.
module tb_simd_serial_alu;

  localparam int LANES = 4;
  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [3:0]  in_lane_en = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_flag;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  simd_serial_alu #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_lane_en (in_lane_en),
    .in_a       (in_a),
    .in_b       (in_b),
    .abort      (abort),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flag   (out_flag),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic per lane.
  function automatic void model_vec(input logic [2:0] op, input logic [3:0] en,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f,
                                    output logic e);
    int unsigned x, y, v;
    bit fl;
    r = '0; f = '0; e = (op > 3'd5);
    for (int i = 0; i < LANES; i++) begin
      x = a[i*8 +: 8]; y = b[i*8 +: 8]; v = 0; fl = 1'b0;
      if (en[i]) begin
        case (op)
          3'd0: begin v = x + y; fl = (v > 255); end
          3'd1: begin v = (x + 256 - y) % 256; fl = (x < y); end
          3'd2: begin v = (x * y) % 256; fl = ((x * y) > 255); end
          3'd3: begin v = (x * y) / 256; end
          3'd4: begin if (y == 0) begin v = 255; fl = 1'b1; end else v = x / y; end
          3'd5: begin if (y == 0) begin v = x; fl = 1'b1; end else v = x % y; end
          default: v = 0;
        endcase
      end
      r[i*8 +: 8] = v[7:0];
      f[i] = fl;
    end
  endfunction

  task automatic start_op(input logic [2:0] op, input logic [3:0] en,
                          input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_op = op; in_lane_en = en; in_a = a; in_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = 3'($urandom); in_lane_en = 4'($urandom); in_a = $urandom; in_b = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL valid_timeout out_valid=%b after %0d cycles", out_valid, lat);
    end
  endtask

  task automatic take(output logic [31:0] r, output logic [3:0] f, output logic e);
    r = out_result; f = out_flag; e = out_err;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [3:0] en,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f,
                       output logic e, output int lat);
    start_op(op, en, a, b);
    wait_valid(lat);
    take(r, f, e);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, busy, out_valid, out_err, out_flag, out_result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b busy=%b vld=%b err=%b flag=%h res=%h required all 0",
               in_ready, busy, out_valid, out_err, out_flag, out_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_add();
    logic [31:0] a, b, r, er; logic [3:0] f, ef; logic e, ee; int lat;
    a = {8'd0, 8'd255, 8'd5, 8'd200};
    b = {8'd0, 8'd1, 8'd3, 8'd100};
    model_vec(3'd0, 4'hF, a, b, er, ef, ee);
    do_op(3'd0, 4'hF, a, b, r, f, e, lat);
    checks++;
    if ({r, f, e} !== {er, ef, ee}) begin
      errors++;
      $display("FAIL add_vec got res=%h flag=%b err=%b required res=%h flag=%b err=%b", r, f, e, er, ef, ee);
    end
    checks++;
    if ({r, f} !== {32'h0000_082C, 4'b0101}) begin
      errors++;
      $display("FAIL add_literal got res=%h flag=%b required 0000082c 0101", r, f);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL add_latency got %0d required 8", lat);
    end
  endtask

  task automatic test_sub_mul();
    logic [31:0] a, b, r, er; logic [3:0] f, ef; logic e, ee; int lat;
    logic [2:0] ops [3];
    logic [31:0] av [3];
    logic [31:0] bv [3];
    ops[0] = 3'd1; av[0] = {16'($urandom), 8'd9, 8'd3};   bv[0] = {16'($urandom), 8'd9, 8'd5};
    ops[1] = 3'd2; av[1] = {16'($urandom), 8'd16, 8'd15}; bv[1] = {16'($urandom), 8'd16, 8'd17};
    ops[2] = 3'd3; av[2] = {24'($urandom), 8'd16};        bv[2] = {24'($urandom), 8'd16};
    for (int t = 0; t < 3; t++) begin
      a = av[t]; b = bv[t];
      model_vec(ops[t], 4'hF, a, b, er, ef, ee);
      do_op(ops[t], 4'hF, a, b, r, f, e, lat);
      checks++;
      if ({r, f, e} !== {er, ef, ee}) begin
        errors++;
        $display("FAIL arith_op%0d got res=%h flag=%b err=%b required res=%h flag=%b err=%b",
                 ops[t], r, f, e, er, ef, ee);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] a, b, r, er; logic [3:0] f, ef; logic e, ee; int lat;
    a = {8'd0, 8'd9, 8'd7, 8'd200};
    b = {8'd0, 8'd3, 8'd0, 8'd7};
    for (int op = 4; op <= 5; op++) begin
      model_vec(3'(op), 4'hF, a, b, er, ef, ee);
      do_op(3'(op), 4'hF, a, b, r, f, e, lat);
      checks++;
      if ({r, f, e} !== {er, ef, ee}) begin
        errors++;
        $display("FAIL div_op%0d got res=%h flag=%b err=%b required res=%h flag=%b err=%b",
                 op, r, f, e, er, ef, ee);
      end
    end
    a = {4{8'd9}}; b = {4{8'd3}};
    do_op(3'd4, 4'hF, a, b, r, f, e, lat);
    checks++;
    if ({r, f} !== {{4{8'd3}}, 4'b0000}) begin
      errors++;
      $display("FAIL div_no_sticky got res=%h flag=%b required 03030303 0000", r, f);
    end
  endtask

  task automatic test_mask_illegal();
    logic [31:0] a, b, r, er; logic [3:0] f, ef; logic e, ee; int lat;
    a = $urandom; b = $urandom;
    model_vec(3'd0, 4'b0101, a, b, er, ef, ee);
    do_op(3'd0, 4'b0101, a, b, r, f, e, lat);
    checks++;
    if ({r, f, e} !== {er, ef, ee} || r[15:8] !== 8'd0 || r[31:24] !== 8'd0) begin
      errors++;
      $display("FAIL mask_add got res=%h flag=%b err=%b required res=%h flag=%b err=%b", r, f, e, er, ef, ee);
    end
    for (int op = 6; op <= 7; op++) begin
      do_op(3'(op), 4'hF, $urandom, $urandom, r, f, e, lat);
      checks++;
      if ({r, f, e} !== {32'd0, 4'd0, 1'b1} || lat !== 8) begin
        errors++;
        $display("FAIL illegal_op%0d got res=%h flag=%b err=%b lat=%0d required 0 0 1 8", op, r, f, e, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, r, er; logic [3:0] f, ef; logic e, ee; int lat;
    a = $urandom; b = $urandom;
    model_vec(3'd2, 4'hF, a, b, er, ef, ee);
    start_op(3'd2, 4'hF, a, b);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_op = 3'd0; in_a = $urandom; in_b = $urandom; in_lane_en = 4'hF;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== er || out_flag !== ef) begin
        errors++;
        $display("FAIL hold_cycle%0d vld=%b rdy=%b res=%h flag=%b required 1 0 %h %b",
                 c, out_valid, in_ready, out_result, out_flag, er, ef);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    a = $urandom; b = $urandom;
    model_vec(3'd0, 4'hF, a, b, er, ef, ee);
    in_valid = 1'b1; in_op = 3'd0; in_lane_en = 4'hF; in_a = a; in_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_next_accept busy=%b required 1", busy);
    end
    wait_valid(lat);
    take(r, f, e);
    checks++;
    if ({r, f, e} !== {er, ef, ee} || lat !== 8) begin
      errors++;
      $display("FAIL hold_next_op got res=%h flag=%b lat=%0d required res=%h flag=%b lat=8", r, f, lat, er, ef);
    end
  endtask

  task automatic test_abort();
    logic [31:0] a, b, r, er; logic [3:0] f, ef; logic e, ee; int lat; int seen;
    start_op(3'd2, 4'hF, $urandom, $urandom);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy busy=%b vld=%b rdy=%b required 0 0 1", busy, out_valid, in_ready);
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_result out_valid high %0d cycles required 0", seen);
    end
    start_op(3'd1, 4'hF, $urandom, $urandom);
    wait_valid(lat);
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0; out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_done busy=%b vld=%b required 0 0", busy, out_valid);
    end
    a = $urandom; b = $urandom;
    model_vec(3'd5, 4'hF, a, b, er, ef, ee);
    abort = 1'b1; in_valid = 1'b1; in_op = 3'd5; in_lane_en = 4'hF; in_a = a; in_b = b;
    @(posedge clk);
    #1;
    abort = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle_accept busy=%b required 1", busy);
    end
    wait_valid(lat);
    take(r, f, e);
    checks++;
    if ({r, f, e} !== {er, ef, ee}) begin
      errors++;
      $display("FAIL abort_idle_op got res=%h flag=%b required res=%h flag=%b", r, f, er, ef);
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] a, b, r, er; logic [3:0] f, ef; logic e, ee; int lat;
    start_op(3'd4, 4'hF, $urandom, $urandom);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, out_valid, out_err, out_flag, out_result} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs rdy=%b busy=%b vld=%b res=%h required all 0",
               in_ready, busy, out_valid, out_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
    a = $urandom; b = $urandom;
    model_vec(3'd3, 4'hF, a, b, er, ef, ee);
    do_op(3'd3, 4'hF, a, b, r, f, e, lat);
    checks++;
    if ({r, f, e} !== {er, ef, ee}) begin
      errors++;
      $display("FAIL rst_mid_clean_op got res=%h flag=%b err=%b required res=%h flag=%b err=%b", r, f, e, er, ef, ee);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er; logic [3:0] f, ef; logic e, ee; int lat;
    logic [2:0] op; logic [3:0] en;
    for (int t = 0; t < 24; t++) begin
      op = 3'($urandom_range(0, 7)); en = 4'($urandom); a = $urandom; b = $urandom;
      for (int i = 0; i < LANES; i++)
        if ($urandom_range(0, 3) == 0) b[i*8 +: 8] = 8'd0;
      model_vec(op, en, a, b, er, ef, ee);
      do_op(op, en, a, b, r, f, e, lat);
      checks++;
      if ({r, f, e} !== {er, ef, ee} || lat !== 8) begin
        errors++;
        $display("FAIL random_%0d op=%0d en=%b a=%h b=%h got res=%h flag=%b err=%b lat=%0d required res=%h flag=%b err=%b",
                 t, op, en, a, b, r, f, e, lat, er, ef, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_div();
    test_mask_illegal();
    test_backpressure();
    test_abort();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
